// File: rtl/fp_add_sub_pipe.sv
// fp_add_sub_pipe: three-stage IEEE 754 adder/subtractor with valid/ready flow control.
// S1 unpacks, resolves special values and aligns; S2 adds/subtracts the aligned significands;
// S3 normalises, rounds to nearest-even, packs and raises the exception flags.
// Subnormal inputs are flushed to signed zero; tiny results flush to signed zero.
module fp_add_sub_pipe #(
  parameter int EXP_BITS  = 8,
  parameter int MANT_BITS = 23,
  parameter int WIDTH     = 1 + EXP_BITS + MANT_BITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             operation_select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_overflow,
  output logic             flag_underflow,
  output logic             flag_inexact,
  output logic             flag_invalid
);

  // Aligned significand: hidden, fraction, guard, round, sticky.
  localparam int SW  = MANT_BITS + 4;
  // Add/sub width: one extra carry bit on top of the aligned field.
  localparam int AW  = MANT_BITS + 5;
  localparam int LZW = $clog2(SW + 1);
  // Working exponent is wide enough to go negative after a full left shift.
  localparam int EW  = EXP_BITS + LZW + 2;
  localparam logic [EXP_BITS-1:0] EXP_ONES = {EXP_BITS{1'b1}};
  localparam logic [WIDTH-1:0]    QNAN     = {1'b0, EXP_ONES, 1'b1, {(MANT_BITS-1){1'b0}}};
  localparam logic [EW-1:0]       EW_ONE   = {{(EW-1){1'b0}}, 1'b1};
  localparam logic [EW-1:0]       EW_MAX   = {{(EW-EXP_BITS){1'b0}}, EXP_ONES};

  // Right shift with every shifted-out bit folded into the sticky position.
  function automatic logic [SW-1:0] align_shift(input logic [SW-1:0] v, input logic [EXP_BITS-1:0] sh);
    logic [SW-1:0] r;
    logic          lost;
    r    = v >> sh;
    lost = 1'b0;
    for (int i = 0; i < SW; i++) begin
      if (i < int'(sh)) lost = lost | v[i];
      else              lost = lost;
    end
    r[0] = r[0] | lost;
    return r;
  endfunction

  // Leading-zero count of the non-carry part of the sum.
  function automatic logic [LZW-1:0] lzc(input logic [SW-1:0] v);
    int   cnt;
    logic found;
    cnt   = 0;
    found = 1'b0;
    for (int i = SW - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      cnt   = cnt + 32'sd1;
      end
    end
    return LZW'(cnt);
  endfunction

  logic adv;

  // Stage registers.
  logic                s1_valid_q, s1_valid_d, s1_sign_q, s1_sign_d, s1_eff_sub_q, s1_eff_sub_d;
  logic [EXP_BITS-1:0] s1_exp_q, s1_exp_d;
  logic [SW-1:0]       s1_mx_q, s1_mx_d, s1_my_q, s1_my_d;
  logic                s1_spec_q, s1_spec_d, s1_spec_inv_q, s1_spec_inv_d;
  logic [WIDTH-1:0]    s1_spec_res_q, s1_spec_res_d;

  logic                s2_valid_q, s2_valid_d, s2_sign_q, s2_sign_d, s2_zsign_q, s2_zsign_d;
  logic [EXP_BITS-1:0] s2_exp_q, s2_exp_d;
  logic [AW-1:0]       s2_sum_q, s2_sum_d;
  logic                s2_spec_q, s2_spec_d, s2_spec_inv_q, s2_spec_inv_d;
  logic [WIDTH-1:0]    s2_spec_res_q, s2_spec_res_d;

  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    result_q, result_d;
  logic                ovf_q, ovf_d, unf_q, unf_d, inx_q, inx_d, inv_q, inv_d;

  // S1 working signals.
  logic                sign_a, sign_b, nan_a, nan_b, snan_a, snan_b, inf_a, inf_b, a_ge_b;
  logic [EXP_BITS-1:0] exp_a, exp_b, exp_x, exp_y, diff;
  logic [MANT_BITS-1:0] frac_a, frac_b, frac_x, frac_y;

  // S3 working signals.
  logic [LZW-1:0]     lz;
  logic [SW-1:0]      sig;
  logic [EW-1:0]      exp_w, exp_r;
  logic [MANT_BITS:0] mant;
  logic [MANT_BITS+1:0] rnd;
  logic [MANT_BITS-1:0] frac_f;
  logic               g_bit, r_bit, s_bit, inc, inexact;

  // The whole pipe moves together; a held output freezes every stage.
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  // S1: unpack, flush subnormals, resolve specials, order by magnitude and align Y.
  always_comb begin
    sign_a = a[WIDTH-1];
    sign_b = b[WIDTH-1] ^ operation_select;
    exp_a  = a[WIDTH-2 -: EXP_BITS];
    exp_b  = b[WIDTH-2 -: EXP_BITS];
    frac_a = (exp_a == {EXP_BITS{1'b0}}) ? {MANT_BITS{1'b0}} : a[MANT_BITS-1:0];
    frac_b = (exp_b == {EXP_BITS{1'b0}}) ? {MANT_BITS{1'b0}} : b[MANT_BITS-1:0];
    nan_a  = (exp_a == EXP_ONES) && (a[MANT_BITS-1:0] != {MANT_BITS{1'b0}});
    nan_b  = (exp_b == EXP_ONES) && (b[MANT_BITS-1:0] != {MANT_BITS{1'b0}});
    snan_a = nan_a && !a[MANT_BITS-1];
    snan_b = nan_b && !b[MANT_BITS-1];
    inf_a  = (exp_a == EXP_ONES) && (a[MANT_BITS-1:0] == {MANT_BITS{1'b0}});
    inf_b  = (exp_b == EXP_ONES) && (b[MANT_BITS-1:0] == {MANT_BITS{1'b0}});
    a_ge_b = {exp_a, frac_a} >= {exp_b, frac_b};

    s1_valid_d   = in_valid;
    s1_eff_sub_d = sign_a ^ sign_b;
    if (a_ge_b) begin
      s1_sign_d = sign_a;
      exp_x = exp_a;  frac_x = frac_a;
      exp_y = exp_b;  frac_y = frac_b;
    end else begin
      s1_sign_d = sign_b;
      exp_x = exp_b;  frac_x = frac_b;
      exp_y = exp_a;  frac_y = frac_a;
    end
    diff     = exp_x - exp_y;
    s1_exp_d = exp_x;
    s1_mx_d  = {(exp_x != {EXP_BITS{1'b0}}), frac_x, 3'b000};
    s1_my_d  = align_shift({(exp_y != {EXP_BITS{1'b0}}), frac_y, 3'b000}, diff);

    s1_spec_d     = 1'b1;
    s1_spec_inv_d = 1'b0;
    s1_spec_res_d = {WIDTH{1'b0}};
    if (nan_a || nan_b) begin
      s1_spec_res_d = QNAN;
      s1_spec_inv_d = snan_a | snan_b;
    end else if (inf_a && inf_b && s1_eff_sub_d) begin
      s1_spec_res_d = QNAN;
      s1_spec_inv_d = 1'b1;
    end else if (inf_a) begin
      s1_spec_res_d = {sign_a, EXP_ONES, {MANT_BITS{1'b0}}};
    end else if (inf_b) begin
      s1_spec_res_d = {sign_b, EXP_ONES, {MANT_BITS{1'b0}}};
    end else begin
      s1_spec_d = 1'b0;
    end
  end

  // S2: magnitude add/sub; X >= Y so the difference never goes negative.
  always_comb begin
    s2_valid_d = s1_valid_q;
    if (s1_eff_sub_q) s2_sum_d = {1'b0, s1_mx_q} - {1'b0, s1_my_q};
    else              s2_sum_d = {1'b0, s1_mx_q} + {1'b0, s1_my_q};
    s2_sign_d     = s1_sign_q;
    // Only an effective addition of two negative zeros yields -0.
    s2_zsign_d    = s1_sign_q & ~s1_eff_sub_q;
    s2_exp_d      = s1_exp_q;
    s2_spec_d     = s1_spec_q;
    s2_spec_res_d = s1_spec_res_q;
    s2_spec_inv_d = s1_spec_inv_q;
  end

  // S3: normalise, round to nearest-even, detect overflow/underflow and pack.
  always_comb begin
    lz = lzc(s2_sum_q[SW-1:0]);
    if (s2_sum_q[AW-1]) begin
      sig   = {s2_sum_q[AW-1:2], s2_sum_q[1] | s2_sum_q[0]};
      exp_w = {{(EW-EXP_BITS){1'b0}}, s2_exp_q} + EW_ONE;
    end else begin
      sig   = s2_sum_q[SW-1:0] << lz;
      exp_w = {{(EW-EXP_BITS){1'b0}}, s2_exp_q} - {{(EW-LZW){1'b0}}, lz};
    end
    g_bit   = sig[2];
    r_bit   = sig[1];
    s_bit   = sig[0];
    inexact = g_bit | r_bit | s_bit;
    inc     = g_bit & (r_bit | s_bit | sig[3]);
    mant    = sig[SW-1:3];
    rnd     = {1'b0, mant} + {{(MANT_BITS+1){1'b0}}, inc};
    if (rnd[MANT_BITS+1]) begin
      exp_r  = exp_w + EW_ONE;
      frac_f = rnd[MANT_BITS:1];
    end else begin
      exp_r  = exp_w;
      frac_f = rnd[MANT_BITS-1:0];
    end

    out_valid_d = s2_valid_q;
    result_d    = {WIDTH{1'b0}};
    ovf_d       = 1'b0;
    unf_d       = 1'b0;
    inx_d       = 1'b0;
    inv_d       = 1'b0;
    if (s2_spec_q) begin
      result_d = s2_spec_res_q;
      inv_d    = s2_spec_inv_q;
    end else if (s2_sum_q == {AW{1'b0}}) begin
      result_d = {s2_zsign_q, {(WIDTH-1){1'b0}}};
    end else if (!exp_r[EW-1] && (exp_r >= EW_MAX)) begin
      result_d = {s2_sign_q, EXP_ONES, {MANT_BITS{1'b0}}};
      ovf_d    = 1'b1;
      inx_d    = 1'b1;
    end else if (exp_r[EW-1] || (exp_r == {EW{1'b0}})) begin
      result_d = {s2_sign_q, {(WIDTH-1){1'b0}}};
      unf_d    = 1'b1;
      inx_d    = 1'b1;
    end else begin
      result_d = {s2_sign_q, exp_r[EXP_BITS-1:0], frac_f};
      inx_d    = inexact;
    end
  end

  // Pipeline registers: synchronous reset clears valids and outputs, advance only on adv.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0; s1_sign_q <= 1'b0; s1_eff_sub_q <= 1'b0; s1_exp_q <= '0;
      s1_mx_q <= '0; s1_my_q <= '0; s1_spec_q <= 1'b0; s1_spec_inv_q <= 1'b0; s1_spec_res_q <= '0;
      s2_valid_q <= 1'b0; s2_sign_q <= 1'b0; s2_zsign_q <= 1'b0; s2_exp_q <= '0;
      s2_sum_q <= '0; s2_spec_q <= 1'b0; s2_spec_inv_q <= 1'b0; s2_spec_res_q <= '0;
      out_valid_q <= 1'b0; result_q <= '0;
      ovf_q <= 1'b0; unf_q <= 1'b0; inx_q <= 1'b0; inv_q <= 1'b0;
    end else if (adv) begin
      s1_valid_q <= s1_valid_d; s1_sign_q <= s1_sign_d; s1_eff_sub_q <= s1_eff_sub_d; s1_exp_q <= s1_exp_d;
      s1_mx_q <= s1_mx_d; s1_my_q <= s1_my_d; s1_spec_q <= s1_spec_d;
      s1_spec_inv_q <= s1_spec_inv_d; s1_spec_res_q <= s1_spec_res_d;
      s2_valid_q <= s2_valid_d; s2_sign_q <= s2_sign_d; s2_zsign_q <= s2_zsign_d; s2_exp_q <= s2_exp_d;
      s2_sum_q <= s2_sum_d; s2_spec_q <= s2_spec_d;
      s2_spec_inv_q <= s2_spec_inv_d; s2_spec_res_q <= s2_spec_res_d;
      out_valid_q <= out_valid_d; result_q <= result_d;
      ovf_q <= ovf_d; unf_q <= unf_d; inx_q <= inx_d; inv_q <= inv_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign result         = result_q;
  assign flag_overflow  = ovf_q;
  assign flag_underflow = unf_q;
  assign flag_inexact   = inx_q;
  assign flag_invalid   = inv_q;

endmodule
